// File: rtl/lj_capture_ctrl_if.sv
// Sample-in / stream-out bundle for lj_capture_ctrl.
//   sample_valid, sample_data : one-cycle sample pulse and word from the sample loader
//   out_valid, out_data       : downstream stream (head of the capture FIFO)
//   out_ready                 : downstream accept
// Modport master is the capture controller's view; slave is the environment's view.
interface lj_capture_ctrl_if #(
    parameter int unsigned N = 16
) ();
    logic         sample_valid;
    logic [N-1:0] sample_data;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_ready;

    modport master (
        input  sample_valid,
        input  sample_data,
        input  out_ready,
        output out_valid,
        output out_data
    );

    modport slave (
        output sample_valid,
        output sample_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/lj_capture_ctrl.sv
// Left-justified audio capture controller.
// Generates the LR frame clock (adclrc) from a free-running bclk counter, and on
// request captures a burst of BURST_LEN samples into a 2-entry FIFO feeding a
// valid/ready stream.
// Ports:
//   bclk, reset_n  : sole clock; synchronous active-low reset
//   start, stop    : begin burst (IDLE only); abort / truncate burst (ARM/CAPTURE)
//   adclrc         : registered LR frame clock, high for the first half of a frame
//   bus (master)   : sample_valid/sample_data in, out_valid/out_data/out_ready stream
//   busy           : controller not idle
//   done           : one-cycle pulse when a burst has fully drained
//   overrun        : sticky, a sample was dropped on a full FIFO this burst
//   sample_count   : samples accepted this burst (saturating at BURST_LEN)
// Optional build macro LJ_CAPTURE_CTRL_DROP_CNT_EN adds drop_count, a 16-bit
// saturating count of dropped samples per burst.
module lj_capture_ctrl #(
    parameter int unsigned N           = 16,
    parameter int unsigned FRAME_BCLKS = 64,
    parameter int unsigned BURST_LEN   = 256
) (
    input  logic                               bclk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic                               stop,
    output logic                               adclrc,
    lj_capture_ctrl_if.master                  bus,
    output logic                               busy,
    output logic                               done,
    output logic                               overrun,
`ifdef LJ_CAPTURE_CTRL_DROP_CNT_EN
    output logic [15:0]                        drop_count,
`endif
    output logic [$clog2(BURST_LEN + 1)-1:0]   sample_count
);
    localparam int unsigned FcW  = $clog2(FRAME_BCLKS);
    localparam int unsigned CntW = $clog2(BURST_LEN + 1);
    localparam logic [FcW-1:0]  FcLast   = FcW'(FRAME_BCLKS - 1);
    localparam logic [FcW-1:0]  FcHalf   = FcW'(FRAME_BCLKS / 2);
    localparam logic [CntW-1:0] CntFull  = CntW'(BURST_LEN);
    localparam logic [CntW-1:0] CntFinal = CntW'(BURST_LEN - 1);

    typedef enum logic [1:0] {StIdle, StArm, StCapture, StDrain} state_e;

    state_e          state_q, state_d;
    logic [FcW-1:0]  frame_cnt_q, frame_cnt_d;
    logic            adclrc_q, adclrc_d;
    logic [N-1:0]    mem_q [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [CntW-1:0] sample_count_q;
    logic            overrun_q;
    logic            frame_last, push_req, pop, full, wr_en, drop, arm_clr;
`ifdef LJ_CAPTURE_CTRL_DROP_CNT_EN
    logic [15:0]     drop_count_q;
`endif

    // Frame counter and registered frame clock.
    always_comb begin
        frame_last  = (frame_cnt_q == FcLast);
        frame_cnt_d = frame_last ? '0 : frame_cnt_q + 1'b1;
        adclrc_d    = (frame_cnt_d < FcHalf);
    end

    // FIFO control. A push into a full FIFO still succeeds if the head pops.
    always_comb begin
        push_req = (state_q == StCapture) && bus.sample_valid;
        pop      = (fifo_cnt_q != 2'd0) && bus.out_ready;
        full     = (fifo_cnt_q == 2'd2);
        wr_en    = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        fifo_cnt_d = fifo_cnt_q;
        if (wr_en && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 2'd1;
        end else if (!wr_en && pop) begin
            fifo_cnt_d = fifo_cnt_q - 2'd1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        arm_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StArm;
                    arm_clr = 1'b1;
                end
            end
            StArm: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (frame_last) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if ((push_req && sample_count_q == CntFinal) || stop) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (fifo_cnt_q == 2'd0) begin
                    state_d = StIdle;
                    done    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge bclk) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            frame_cnt_q    <= FcLast;
            adclrc_q       <= 1'b0;
            mem_q[0]       <= '0;
            mem_q[1]       <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            fifo_cnt_q     <= 2'd0;
            sample_count_q <= '0;
            overrun_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            adclrc_q    <= adclrc_d;
            fifo_cnt_q  <= fifo_cnt_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= bus.sample_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (arm_clr) begin
                sample_count_q <= '0;
            end else if (push_req && sample_count_q != CntFull) begin
                sample_count_q <= sample_count_q + 1'b1;
            end
            if (arm_clr) begin
                overrun_q <= 1'b0;
            end else if (drop) begin
                overrun_q <= 1'b1;
            end
        end
    end

`ifdef LJ_CAPTURE_CTRL_DROP_CNT_EN
    always_ff @(posedge bclk) begin
        if (!reset_n) begin
            drop_count_q <= '0;
        end else if (arm_clr) begin
            drop_count_q <= '0;
        end else if (drop && drop_count_q != 16'hFFFF) begin
            drop_count_q <= drop_count_q + 16'd1;
        end
    end

    assign drop_count = drop_count_q;
`endif

    assign adclrc        = adclrc_q;
    assign bus.out_valid = (fifo_cnt_q != 2'd0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign busy          = (state_q != StIdle);
    assign overrun       = overrun_q;
    assign sample_count  = sample_count_q;
endmodule

// File: doc/lj_capture_ctrl.md
LJ_CAPTURE_CTRL -- requirements
Module: lj_capture_ctrl

Interface
REQ-001 SHALL have parameters: N, 16, sample width; FRAME_BCLKS, 64, bclk cycles per LR frame (even, >=2*N+2); BURST_LEN, 256, samples per capture burst (>=1).
REQ-002 SHALL have ports: bclk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have ports: reset_n  in  1  synchronous active-low reset.
REQ-004 SHALL have ports: start  in  1  begin burst (level sampled when IDLE); stop  in  1  abort/truncate burst.
REQ-005 SHALL have ports: adclrc  out  1  generated LR frame clock to CODEC and sample loader.
REQ-006 SHALL have ports: sample_valid  in  1  one-cycle pulse from sample loader; sample_data  in  N  loaded sample.
REQ-007 SHALL have ports: out_valid  out  1; out_data  out  N; out_ready  in  1  -- downstream valid/ready stream.
REQ-008 SHALL have ports: busy  out  1  state != IDLE; done  out  1  one-cycle end-of-burst pulse; overrun  out  1  sticky drop flag; sample_count  out  clog2(BURST_LEN+1)  samples accepted this burst.

Function
REQ-009 SHALL keep free-running frame_cnt 0..FRAME_BCLKS-1, +1 per cycle, wrapping to 0; adclrc = 1 iff frame_cnt < FRAME_BCLKS/2 (from registered count, glitch-free).
REQ-010 SHALL define frame boundary as frame_cnt == FRAME_BCLKS-1 (cycle before adclrc rises).
REQ-011 SHALL implement FSM IDLE, ARM, CAPTURE, DRAIN.
REQ-012 IDLE->ARM on start=1; sample_count and overrun cleared on that transition; start ignored in all other states.
REQ-013 ARM->CAPTURE at frame boundary; ARM->IDLE on stop (no done pulse).
REQ-014 In CAPTURE, each sample_valid pushes sample_data into 2-entry FIFO and increments sample_count; sample_valid in any other state is ignored.
REQ-015 CAPTURE->DRAIN in the cycle sample_count reaches BURST_LEN, or on stop (truncated burst); push in that same cycle is still accepted.
REQ-016 DRAIN->IDLE when FIFO empty; done=1 for exactly that one cycle.
REQ-017 out_valid = FIFO non-empty; out_data = head entry; pop when out_valid & out_ready; out_data stable while out_valid & !out_ready.
REQ-018 Latency: sample pushed at cycle t into empty FIFO SHALL appear on out_valid/out_data at t+1.
REQ-019 Push when FIFO full and no pop same cycle: sample dropped, sample_count still increments, overrun set sticky until next IDLE->ARM.
REQ-020 Push and pop same cycle when full: both succeed, no overrun.
REQ-021 stop and start asserted together in IDLE: start wins (stop only acts in ARM/CAPTURE).
REQ-022 sample_count saturates at BURST_LEN.

Reset
REQ-023 reset_n=0 on a bclk edge SHALL force: state IDLE, frame_cnt FRAME_BCLKS-1 (adclrc=0), FIFO empty, out_valid 0, busy 0, done 0, overrun 0, sample_count 0, out_data 0.
REQ-024 First cycle after reset release SHALL have frame_cnt 0, adclrc 1 (rising edge).
REQ-025 Reset mid-burst SHALL discard FIFO contents without done pulse.

Configuration
REQ-026 Macro LJ_CAPTURE_CTRL_DROP_CNT_EN: when defined, adds output drop_count (16 bits, saturating) counting dropped samples per burst, cleared with overrun; when undefined, port and counter absent, overrun behaviour unchanged.

Verification
REQ-027 Reset release, FRAME_BCLKS=64 -> adclrc high cycles 0-31, low 32-63, period 64, repeats.
REQ-028 start at frame_cnt=10, BURST_LEN=4, out_ready=1, 4 sample_valid pulses after CAPTURE -> 4 words out in order, each 1 cycle after push, done pulse once, sample_count=4.
REQ-029 out_ready=0, 3 pushes (0xAAAA,0xBBBB,0xCCCC) -> FIFO holds first two, overrun=1, releasing out_ready yields 0xAAAA then 0xBBBB.
REQ-030 stop after 2 of BURST_LEN=256 samples -> DRAIN, both words delivered, done pulse, sample_count=2.
REQ-031 stop in ARM -> IDLE, no done, no output; sample_valid in IDLE -> no output.
REQ-032 reset_n=0 with 2 words queued -> out_valid=0 next cycle, busy=0, adclrc=0; with LJ_CAPTURE_CTRL_DROP_CNT_EN, scenario REQ-029 gives drop_count=1.
